mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single-port summing RAM (5-bit address, rden/wren strobes) between the accumulation sequencer and a host load/readback port. It serializes word accesses, drives the RAM strobes itself, and returns read data to the owning requester with a one-cycle valid pulse. It sits between both requesters and the RAM, so neither requester drives the RAM directly.

## Interface
Parameters:
- AW, 5, RAM address width
- DW, 16, RAM data width
- RD_LAT, 1, RAM read latency in cycles from strobe-sampling edge to valid mem_q (legal 1..3)

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, port 0 = sequencer, port 1 = host
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid for that port
- rdata  out  DW  registered read data, shared by both ports
- busy  out  1  high whenever state is not IDLE
- mem_address  out  AW  RAM address
- mem_rden / mem_wren  out  1  RAM read / write strobes
- mem_data  out  DW  RAM write data
- mem_q  in  DW  RAM read data

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if neither req is high, stay. Otherwise select the winner, latch owner, addr, we, and wdata, then go to ACCESS.
- ACCESS, 1 cycle: gnt[owner]=1; mem_address=latched addr; mem_wren=we; mem_rden=~we; mem_data=latched wdata. On a write, go to IDLE. On a read, go to WAIT.
- WAIT: stay RD_LAT cycles using a wait counter. On the final WAIT edge, capture mem_q into rdata, then go to RESP.
- RESP, 1 cycle: rvalid[owner]=1, then go to IDLE.
- Requester rules:
  - A requester holds req, we, addr, and wdata stable until its gnt.
  - Inputs are ignored outside IDLE.
  - Dropping req after gnt does not cancel the pending rvalid.
  - Dropping req before acceptance means the request is not served.
- Only one of gnt0/gnt1 and one of rvalid0/rvalid1 is ever high, and never both gnt and rvalid in the same cycle.
- mem_rden and mem_wren are never high together, and both are high only in ACCESS.
- rdata holds its last captured value until the next read capture.

## Timing
- Reset (async, immediate): state=IDLE; gnt*, rvalid*, busy, mem_rden, mem_wren = 0; mem_address=0; mem_data=0; rdata=0; last_owner=1.
- Request seen at edge E0 in IDLE:
  - gnt and the strobes are high in cycle E0+1.
  - For a read, rvalid is high in cycle E0+RD_LAT+2.
- Spacing: back-to-back writes take 2 cycles each; back-to-back reads take RD_LAT+3 cycles each.
- Arbitration decisions are made only in IDLE and use the req values sampled at that edge.
- Reset asserted mid-transaction aborts it: no rvalid is issued and the RAM strobes drop immediately. After release, arbitration restarts in IDLE.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - If both req are high, grant the port that is not last_owner.
  - last_owner updates on each ACCESS.
  - After reset, port 0 wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties. last_owner is not implemented.

## Test plan
- Single write: reset, then req1=1, we1=1, addr1=5, wdata1=16'h00A5.
  - Expect gnt1 exactly 1 cycle after the request is sampled, mem_wren=1, mem_address=5, mem_data=16'h00A5.
  - busy low 2 cycles after the request.
- Single read, RD_LAT=1: RAM preloaded with addr 7 = 16'h1234; req0=1, we0=0, addr0=7.
  - Expect gnt0 at +1, rvalid0 at +3, rdata=16'h1234, mem_rden high only at +1.
- Contention, round-robin build: req0 and req1 both held high for reads of addr 3 and 4.
  - Expect grant order 0, 1, 0, 1.
  - Fixed-priority build: expect 0, 0, 0 while req0 is held.
- Request withdrawal: req0 pulsed for 1 cycle while busy serving port 1.
  - Expect no gnt0 and no RAM access to addr0.
- Reset mid-read: assert reset during WAIT.
  - Expect strobes and busy at 0 immediately, no rvalid, rdata=0.
  - After release, a new read of addr 2 completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port summing RAM. Fixed priority (port 0 wins ties)
// by default; define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_port_arbiter #(
  parameter int AW     = 5,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic          mem_rden,
  output logic          mem_wren,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q
);

  // Handshake: a requester holds req/we/addr/wdata stable until its one-cycle gnt;
  // a read then returns rdata with a one-cycle rvalid on the owning port, even if
  // req has been dropped after gnt. Requests are only sampled in IDLE.
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t          state;
  logic            owner;
  logic            we_q;
  logic [1:0]      wait_cnt;
  logic            pick1;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

`ifdef MEM_ARB_RR_EN
  logic last_owner;

  // On a tie, the port that did not own the previous access wins.
  always_comb pick1 = req1 && (!req0 || !last_owner);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_owner <= 1'b1;
    end else if (state == ACCESS) begin
      last_owner <= owner;
    end
  end
`else
  always_comb pick1 = req1 && !req0;
`endif

  always_comb begin
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      we_q        <= 1'b0;
      wait_cnt    <= 2'd0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata       <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner       <= pick1;
            we_q        <= sel_we;
            mem_address <= sel_addr;
            mem_data    <= sel_wdata;
            gnt0        <= !pick1;
            gnt1        <= pick1;
            mem_wren    <= sel_we;
            mem_rden    <= !sel_we;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          mem_rden <= 1'b0;
          mem_wren <= 1'b0;
          wait_cnt <= 2'(RD_LAT - 1);
          state    <= we_q ? IDLE : WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            rdata   <= mem_q;
            rvalid0 <= !owner;
            rvalid1 <= owner;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RD_LAT=1 RAM model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic        busy;
  logic [4:0]  mem_address;
  logic        mem_rden, mem_wren;
  logic [15:0] mem_data;
  logic [15:0] mem_q;

  int n_checks = 0;
  int n_err    = 0;
  int acc9     = 0;

  mem_port_arbiter #(.AW(5), .DW(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, one-cycle read latency
  logic [15:0] ram [32];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    if (mem_rden) mem_q <= ram[mem_address];
  end

  always @(posedge clk)
    if ((mem_rden || mem_wren) && mem_address == 5'd9) acc9 <= acc9 + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // protocol invariants every cycle out of reset
  always @(negedge clk) begin
    if (reset) begin
      check("excl", {31'd0, (gnt0 & gnt1) | (rvalid0 & rvalid1) |
                           ((gnt0 | gnt1) & (rvalid0 | rvalid1)) |
                           (mem_rden & mem_wren) |
                           ((mem_rden | mem_wren) & !(gnt0 | gnt1))}, 32'd0);
    end
  end

  // driver tasks
  task automatic drive(input int port, input logic we, input logic [4:0] a, input logic [15:0] d);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic do_write(input int port, input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    drive(port, 1'b1, a, d);
    @(negedge clk);
    check("wr_gnt",    {31'd0, port == 0 ? gnt0 : gnt1}, 32'd1);
    check("wr_ogn",    {31'd0, port == 0 ? gnt1 : gnt0}, 32'd0);
    check("wr_wren",   {31'd0, mem_wren}, 32'd1);
    check("wr_addr",   {27'd0, mem_address}, {27'd0, a});
    check("wr_data",   {16'd0, mem_data}, {16'd0, d});
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("wr_idle",   {30'd0, busy, mem_wren}, 32'd0);
    check("wr_ram",    {16'd0, ram[a]}, {16'd0, d});
  endtask

  task automatic do_read(input int port, input logic [4:0] a, input logic [15:0] exp);
    @(negedge clk);
    drive(port, 1'b0, a, 16'h0);
    @(negedge clk);
    check("rd_gnt",    {31'd0, port == 0 ? gnt0 : gnt1}, 32'd1);
    check("rd_rden",   {30'd0, mem_rden, mem_wren}, 32'd2);
    check("rd_addr",   {27'd0, mem_address}, {27'd0, a});
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("rd_wait",   {29'd0, mem_rden, rvalid0, rvalid1}, 32'd0);
    @(negedge clk);
    check("rd_rvalid", {30'd0, rvalid0, rvalid1}, port == 0 ? 32'd2 : 32'd1);
    check("rd_data",   {16'd0, rdata}, {16'd0, exp});
    @(negedge clk);
    check("rd_done",   {30'd0, busy, rvalid0 | rvalid1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int exp_order[4];
    int rv, g0;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    reset = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", {26'd0, gnt0, gnt1, rvalid0, rvalid1, mem_rden, mem_wren}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {27'd0, mem_address}, 32'd0);
    check("rst_data", {mem_data, rdata}, 32'd0);
    reset = 1'b1;

    // single write and read, plus preloads
    do_write(1, 5'd5, 16'h00A5);
    do_write(0, 5'd7, 16'h1234);
    do_read(0, 5'd7, 16'h1234);
    do_write(0, 5'd3, 16'h0333);
    do_write(1, 5'd4, 16'h0444);
    do_write(0, 5'd2, 16'h2222);
    do_read(1, 5'd5, 16'h00A5);

    // contention from a fresh reset
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(0, 1'b0, 5'd3, 16'h0);
    drive(1, 1'b0, 5'd4, 16'h0);
    rv = 0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      if (rvalid0) begin rv++; check("ct_rdata0", {16'd0, rdata}, 32'h0333); end
      if (rvalid1) begin rv++; check("ct_rdata1", {16'd0, rdata}, 32'h0444); end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid0) begin rv++; check("ct_rdata0", {16'd0, rdata}, 32'h0333); end
      if (rvalid1) begin rv++; check("ct_rdata1", {16'd0, rdata}, 32'h0444); end
    end
    check("ct_ngnt", order.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check("ct_order", i < order.size() ? order[i] : 9, exp_order[i]);
    check("ct_nrv", rv, 32'd4);
    check("ct_idle", {31'd0, busy}, 32'd0);

    // port 0 pulses req while port 1 is being served
    @(negedge clk);
    drive(1, 1'b0, 5'd4, 16'h0);
    @(negedge clk);
    check("wd_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    drive(0, 1'b1, 5'd9, 16'hDEAD);
    @(negedge clk);
    req0 = 1'b0;
    g0 = 0; rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt0) g0++;
      if (rvalid1) begin rv++; check("wd_rdata", {16'd0, rdata}, 32'h0444); end
    end
    check("wd_nognt0", g0, 32'd0);
    check("wd_noacc9", acc9, 32'd0);
    check("wd_rv1", rv, 32'd1);

    // reset during WAIT aborts the read
    @(negedge clk);
    drive(0, 1'b0, 5'd2, 16'h0);
    @(negedge clk);
    check("rm_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    check("rm_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rm_strobes", {29'd0, mem_rden, mem_wren, busy}, 32'd0);
    check("rm_rdata", {16'd0, rdata}, 32'd0);
    rv = 0;
    repeat (3) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) rv++;
    end
    check("rm_norv", rv, 32'd0);
    reset = 1'b1;
    do_read(0, 5'd2, 16'h2222);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
